// File: rtl/pkt_proc_sched.sv
// Per-packet scheduler between the SRAM packet FIFO and the processor datapath.
// Optional watchdog on the RUN phase is built when SCHED_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | no packet resident, waiting for sched_en & pkt_valid
// PRST     | FIFO frozen, processor held in reset
// RUN      | processor executing over the resident packet
// REL      | one-cycle release command to the FIFO
// WAIT_REL | waiting for the FIFO to finish forward/discard
module pkt_proc_sched #(
    parameter int PROC_RST_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int TWIDTH          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sched_en,
    input  logic        pkt_valid,
    input  logic        proc_done,
    input  logic        proc_drop,
    input  logic        rel_done,
    output logic        pc_en,
    output logic        proc_rst,
    output logic        stall,
    output logic        rel_start,
    output logic        rel_drop,
    output logic        busy,
    output logic [31:0] pkt_count,
    output logic [31:0] drop_count,
    output logic [15:0] tmo_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRST     = 3'd1,
        RUN      = 3'd2,
        REL      = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    localparam logic [7:0] PRST_LOAD = 8'(PROC_RST_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] prst_cnt;
    logic       tmo_hit;

    // Elaboration-time guard on the parameter ranges the datapath relies on.
    if (PROC_RST_CYCLES < 1 || PROC_RST_CYCLES > 255 || TIMEOUT_CYCLES < 2 ||
        longint'(TIMEOUT_CYCLES) >= (longint'(1) << TWIDTH)) begin : g_param_chk
        $error("pkt_proc_sched: illegal parameter combination");
    end

`ifdef SCHED_TIMEOUT_EN
    localparam logic [TWIDTH-1:0] WD_LAST = TWIDTH'(TIMEOUT_CYCLES - 1);

    logic [TWIDTH-1:0] wd_cnt;

    assign tmo_hit = (state == RUN) && (wd_cnt == WD_LAST);

    // Held at zero outside RUN so the first RUN cycle always sees a fresh count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state != RUN) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_count <= '0;
        end else if (tmo_hit && !proc_done) begin
            tmo_count <= tmo_count + 16'd1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign tmo_count = '0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (sched_en && pkt_valid) state_nxt = PRST;
            PRST:     if (prst_cnt == 8'd0) state_nxt = RUN;
            RUN:      if (proc_done || tmo_hit) state_nxt = REL;
            REL:      state_nxt = WAIT_REL;
            WAIT_REL: if (rel_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prst_cnt <= '0;
        end else if (state != PRST) begin
            prst_cnt <= PRST_LOAD;
        end else if (prst_cnt != 8'd0) begin
            prst_cnt <= prst_cnt - 8'd1;
        end
    end

    // Outputs are decoded from the next state so every output comes straight off a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc_en      <= 1'b0;
            proc_rst   <= 1'b0;
            stall      <= 1'b0;
            busy       <= 1'b0;
            rel_start  <= 1'b0;
            rel_drop   <= 1'b0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            state     <= state_nxt;
            pc_en     <= (state_nxt == RUN);
            proc_rst  <= (state_nxt == PRST);
            stall     <= (state_nxt != IDLE);
            busy      <= (state_nxt != IDLE);
            rel_start <= (state_nxt == REL);

            // A processor verdict beats a simultaneous watchdog expiry.
            if (state == RUN && proc_done) begin
                rel_drop <= proc_drop;
            end else if (tmo_hit) begin
                rel_drop <= 1'b1;
            end else if (state_nxt == IDLE) begin
                rel_drop <= 1'b0;
            end

            if (state == WAIT_REL && rel_done) begin
                if (rel_drop) begin
                    drop_count <= drop_count + 32'd1;
                end else begin
                    pkt_count <= pkt_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_proc_sched.sv
// Self-checking bench for pkt_proc_sched: directed and randomized packets checked
// against a transaction-level model of phase lengths, verdicts and counters.
module tb_pkt_proc_sched;

    localparam int P = 4;
    localparam int T = 16;
`ifdef SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sched_en, pkt_valid, proc_done, proc_drop, rel_done;
    logic        pc_en, proc_rst, stall, rel_start, rel_drop, busy;
    logic [31:0] pkt_count, drop_count;
    logic [15:0] tmo_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int pkt_m    = 0;
    int drop_m   = 0;
    int tmo_m    = 0;

    pkt_proc_sched #(
        .PROC_RST_CYCLES(P),
        .TIMEOUT_CYCLES (T),
        .TWIDTH         (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sched_en  (sched_en),
        .pkt_valid (pkt_valid),
        .proc_done (proc_done),
        .proc_drop (proc_drop),
        .rel_done  (rel_done),
        .pc_en     (pc_en),
        .proc_rst  (proc_rst),
        .stall     (stall),
        .rel_start (rel_start),
        .rel_drop  (rel_drop),
        .busy      (busy),
        .pkt_count (pkt_count),
        .drop_count(drop_count),
        .tmo_count (tmo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_pkt_count"}, pkt_count, 64'(pkt_m));
        chk({tag, "_drop_count"}, drop_count, 64'(drop_m));
        chk({tag, "_tmo_count"}, tmo_count, 64'(tmo_m));
    endtask

    // One packet: d = RUN cycle on which proc_done fires (0 = never),
    // rdel = cycles from rel_start to the rel_done pulse.
    task automatic run_pkt(input int d, input bit drop, input int rdel,
                           input bit keep, input bit kill_en, input bit spur);
        int   prst_n, run_n, ovl, hold_err;
        bit   tmo;
        logic exp_drop;
        int   run_exp;
        pkt_valid = 1'b1;
        sched_en  = 1'b1;
        step();
        chk("start_stall", stall, 1);
        chk("start_busy", busy, 1);
        prst_n = 0;
        ovl    = 0;
        while (proc_rst === 1'b1 && prst_n < 300) begin
            if (pc_en !== 1'b0) ovl++;
            if (!keep) pkt_valid = 1'b0;
            prst_n++;
            step();
        end
        chk("prst_len", prst_n, 64'(P));
        chk("prst_pc_overlap", ovl, 0);

        tmo      = TMO_EN && (d == 0 || d > T);
        run_exp  = tmo ? T : d;
        exp_drop = tmo ? 1'b1 : drop;
        run_n    = 0;
        while (pc_en === 1'b1 && run_n < 5000) begin
            run_n++;
            if (kill_en) sched_en = 1'b0;
            rel_done = spur && (run_n == 2);
            if (run_n == d) begin
                proc_done = 1'b1;
                proc_drop = drop;
            end else begin
                proc_done = 1'b0;
                proc_drop = 1'($urandom);
            end
            step();
        end
        proc_done = 1'b0;
        rel_done  = 1'b0;
        chk("run_len", run_n, 64'(run_exp));
        chk("rel_start_pulse", rel_start, 1);
        chk("rel_drop_at_rel", rel_drop, exp_drop);
        chk("proc_rst_in_rel", proc_rst, 0);

        hold_err = 0;
        for (int i = 1; i <= rdel; i++) begin
            step();
            if (rel_start !== 1'b0 || rel_drop !== exp_drop || busy !== 1'b1 || stall !== 1'b1)
                hold_err++;
            if (i == rdel) rel_done = 1'b1;
        end
        chk("wait_rel_hold", hold_err, 0);
        step();
        rel_done = 1'b0;
        if (!keep) pkt_valid = 1'b0;
        if (exp_drop) drop_m++;
        else pkt_m++;
        if (tmo) tmo_m++;
        chk("end_busy", busy, 0);
        chk("end_stall", stall, 0);
        chk_counters("end");
    endtask

    initial begin
        int guard, gap, stay_busy;
        reset     = 1'b1;
        sched_en  = 1'b0;
        pkt_valid = 1'b0;
        proc_done = 1'b0;
        proc_drop = 1'b0;
        rel_done  = 1'b0;
        repeat (3) step();
        chk("rst_pc_en", pc_en, 0);
        chk("rst_proc_rst", proc_rst, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rel_start", rel_start, 0);
        chk("rst_rel_drop", rel_drop, 0);
        chk("rst_busy", busy, 0);
        chk_counters("rst");
        reset = 1'b0;

        // Disabled scheduler must not pick up a waiting packet.
        pkt_valid = 1'b1;
        stay_busy = 0;
        repeat (5) begin
            step();
            if (busy !== 1'b0) stay_busy++;
        end
        chk("disabled_idle", stay_busy, 0);

        // Spurious strobes in IDLE.
        pkt_valid = 1'b0;
        sched_en  = 1'b1;
        rel_done  = 1'b1;
        proc_done = 1'b1;
        step();
        rel_done  = 1'b0;
        proc_done = 1'b0;
        step();
        chk("spur_idle_busy", busy, 0);
        chk_counters("spur_idle");

        run_pkt(10, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        run_pkt(10, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        run_pkt(TMO_EN ? 0 : 1000, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        run_pkt(T, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        run_pkt(5, 1'b0, 2, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            run_pkt(int'($urandom_range(1, T + 6)), 1'($urandom), int'($urandom_range(1, 5)),
                    1'b0, 1'b0, 1'($urandom));
            gap = int'($urandom_range(0, 3));
            repeat (gap) step();
        end

        // Asynchronous reset in the middle of RUN.
        pkt_valid = 1'b1;
        sched_en  = 1'b1;
        guard     = 0;
        while (pc_en !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        chk("mid_rst_reached_run", pc_en, 1);
        repeat (3) step();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_pc_en", pc_en, 0);
        chk("mid_rst_proc_rst", proc_rst, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_rel_start", rel_start, 0);
        chk("mid_rst_rel_drop", rel_drop, 0);
        chk("mid_rst_busy", busy, 0);
        pkt_m  = 0;
        drop_m = 0;
        tmo_m  = 0;
        chk_counters("mid_rst");
        step();
        reset = 1'b0;
        run_pkt(6, 1'b0, 1, 1'b0, 1'b0, 1'b0);

        // Back-to-back with sched_en withdrawn during packet 2.
        step();
        reset = 1'b1;
        step();
        reset  = 1'b0;
        pkt_m  = 0;
        drop_m = 0;
        tmo_m  = 0;
        run_pkt(4, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        run_pkt(5, 1'b0, 2, 1'b1, 1'b1, 1'b0);
        stay_busy = 0;
        repeat (6) begin
            step();
            if (busy !== 1'b0 || proc_rst !== 1'b0) stay_busy++;
        end
        chk("b2b_no_third", stay_busy, 0);
        chk("b2b_pkt_count", pkt_count, 2);
        chk("b2b_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_proc_sched.md
# pkt_proc_sched

Per-packet scheduler between the SRAM packet FIFO and the processor datapath. It detects a complete stored packet and freezes FIFO input while the packet is resident. It then resets and runs the processor over the packet. On completion or watchdog expiry it commands the FIFO to forward or discard the packet, and counts the outcome.

## Interface
Parameters:
- PROC_RST_CYCLES, 4: cycles proc_rst is held before each run (1..255)
- TIMEOUT_CYCLES, 4096: watchdog limit for RUN, in cycles (≥2)
- TWIDTH, 16: width of watchdog counter; TIMEOUT_CYCLES < 2^TWIDTH

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- sched_en  in  1  software enable; sampled only in IDLE
- pkt_valid  in  1  FIFO holds one complete packet (level)
- proc_done  in  1  processor finished current packet (pulse or level)
- proc_drop  in  1  drop verdict, sampled with proc_done
- rel_done  in  1  FIFO finished forwarding/discarding (pulse)
- pc_en  out  1  processor run enable
- proc_rst  out  1  processor PC/register reset
- stall  out  1  block new FIFO writes
- rel_start  out  1  one-cycle release command
- rel_drop  out  1  release mode: 1 discard, 0 forward
- busy  out  1  state ≠ IDLE
- pkt_count  out  32  packets forwarded
- drop_count  out  32  packets discarded
- tmo_count  out  16  watchdog expiries

## Operation
- States: IDLE, PRST, RUN, REL, WAIT_REL. Registered one-hot or binary; all outputs registered.
- IDLE: when sched_en & pkt_valid, go to PRST. Otherwise stay.
- PRST: proc_rst=1, pc_en=0. A down-counter is loaded with PROC_RST_CYCLES−1. At zero, go to RUN.
- RUN: pc_en=1. The watchdog counter is cleared on entry and increments each cycle.
  - proc_done=1: latch rel_drop=proc_drop, go to REL.
  - Watchdog reaches TIMEOUT_CYCLES−1 without proc_done: rel_drop=1, tmo_count+1, go to REL.
  - proc_done and expiry in the same cycle: proc_done wins and tmo_count is not incremented.
- REL: pc_en=0, rel_start=1 for exactly one cycle, then go to WAIT_REL.
- WAIT_REL: hold rel_drop. On rel_done, increment pkt_count (rel_drop=0) or drop_count (rel_drop=1), then go to IDLE.
- stall=1 in PRST, RUN, REL and WAIT_REL. It is 0 only in IDLE.
- rel_done outside WAIT_REL is ignored. proc_done outside RUN is ignored.
- Counters wrap modulo 2^width and are never cleared except by reset.
- sched_en deassertion mid-packet does not abort; the current packet completes.
- pkt_valid dropping mid-packet is ignored.

## Timing
- Reset (asynchronous): state=IDLE. pc_en, proc_rst, stall, rel_start, rel_drop and busy are 0. All counters are 0.
- Edge N samples sched_en & pkt_valid in IDLE. At N+1: stall=1, proc_rst=1, busy=1.
- proc_rst is high for exactly PROC_RST_CYCLES cycles. pc_en rises on the cycle after proc_rst falls; there is no overlap.
- proc_done sampled at edge M. At M+1: pc_en=0, rel_start=1. At M+2: rel_start=0.
- rel_done sampled at edge K. At K+1: the counter is updated, stall=0 and busy=0.
- Earliest next PRST: one cycle after returning to IDLE. Minimum packet turnaround is PROC_RST_CYCLES+4 cycles.
- Watchdog: with no proc_done, pc_en is high for exactly TIMEOUT_CYCLES cycles.

## Configuration
- SCHED_TIMEOUT_EN defined: watchdog active as described. tmo_count counts expiries.
- Not defined: no watchdog counter is synthesized and RUN waits indefinitely for proc_done. tmo_count is tied to 0.

## Test plan
- Reset mid-RUN (assert reset 1 ns after a clock edge) → all outputs 0 immediately, state IDLE. After release, with pkt_valid=1 and sched_en=1, a fresh PRST sequence starts.
- Forward path: PROC_RST_CYCLES=4, pkt_valid=1, proc_done 10 cycles into RUN with proc_drop=0, rel_done 3 cycles after rel_start →
  - proc_rst high 4 cycles, then pc_en high 10 cycles;
  - rel_start one-cycle pulse with rel_drop=0;
  - pkt_count=1 and stall=0 one cycle after rel_done.
- Drop verdict: same stimulus but proc_drop=1 → rel_drop=1 through WAIT_REL; drop_count=1, pkt_count unchanged.
- Watchdog (macro defined, TIMEOUT_CYCLES=16), proc_done never asserted → pc_en high exactly 16 cycles, rel_drop=1, tmo_count=1, then drop_count=1. With the macro undefined, pc_en stays high 1000 cycles and tmo_count=0.
- Tie-break and spurious inputs:
  - proc_done on the watchdog expiry cycle with proc_drop=0 → forwarded, tmo_count=0;
  - rel_done pulsed in IDLE and in RUN → no counter change.
- Back-to-back 3 packets with pkt_valid held high, sched_en dropped during packet 2 → packet 2 completes, packet 3 does not start; final pkt_count=2, busy=0.
